// File: rtl/nic_ring_node.sv
// One station on the slotted NIC packet ring: ejects local packets into an RX FIFO,
// forwards transit traffic with age+1, drops aged-out packets and injects TX into free slots.
package nic_pkg;
    localparam logic [3:0] PT_NULL   = 4'd0;
    localparam logic [3:0] PT_READ   = 4'd1;
    localparam logic [3:0] PT_WRITE  = 4'd2;
    localparam logic [3:0] PT_ACK    = 4'd3;
    localparam logic [3:0] PT_RETRY  = 4'd4;
    localparam logic [3:0] PT_AREAD  = 4'd5;
    localparam logic [3:0] PT_AWRITE = 4'd6;

    typedef struct packed {
        logic [4:0]  rsvd;
        logic [5:0]  did;
        logic [5:0]  sid;
        logic [5:0]  age;
        logic [3:0]  typ;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } packet_t;
endpackage

module nic_ring_node
    import nic_pkg::*;
#(
    parameter logic [5:0] NODE_ID   = 6'd1,
    parameter logic [5:0] MAX_AGE   = 6'd63,
    parameter int         RXQ_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [95:0] ring_i,
    output logic [95:0] ring_o,
    output logic [95:0] rx_pkt_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    input  logic [95:0] tx_pkt_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        drop_o,
    output logic [4:0]  rxq_count_o
);
    localparam int PW = (RXQ_DEPTH > 1) ? $clog2(RXQ_DEPTH) : 1;

    packet_t        slot;
    packet_t        tx;
    packet_t        ring_d;
    packet_t        ring_q;
    logic           drop_q;
    logic [4:0]     count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [95:0]    mem [RXQ_DEPTH];
    logic           full;
    logic           push;
    logic           pop;
    logic           aged;
    logic           free;

    assign slot = packet_t'(ring_i);
    assign tx   = packet_t'(tx_pkt_i);

    // Slot classification; fullness is judged before any same-cycle pop.
    always_comb begin
        full   = (count == 5'(RXQ_DEPTH));
        push   = 1'b0;
        aged   = 1'b0;
        free   = 1'b0;
        ring_d = '0;
        if (slot.typ == PT_NULL) begin
            free = 1'b1;
        end else if (slot.did == NODE_ID && !full) begin
            push = 1'b1;
            free = 1'b1;
        end else if (slot.age == MAX_AGE) begin
            aged = 1'b1;
            free = 1'b1;
        end else begin
            ring_d     = slot;
            ring_d.age = (slot.age >= MAX_AGE) ? MAX_AGE : slot.age + 6'd1;
        end
        if (free && tx_valid_i) begin
            ring_d      = tx;
            ring_d.sid  = NODE_ID;
            ring_d.age  = '0;
            ring_d.rsvd = '0;
        end
    end

    assign pop = (count != 5'd0) && rx_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ring_q <= '0;
            drop_q <= 1'b0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            ring_q <= ring_d;
            drop_q <= aged;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= slot;
    end

    assign ring_o      = ring_q;
    assign drop_o      = drop_q;
    assign rx_pkt_o    = mem[rd_ptr];
    assign rx_valid_o  = (count != 5'd0);
    assign rxq_count_o = count;
    assign tx_ready_o  = free;
endmodule

// File: tb/tb_nic_ring_node.sv
// Self-checking bench for nic_ring_node: directed scenarios plus a randomized run
// compared against a queue-based reference model of the ring station.
module tb_nic_ring_node;
    import nic_pkg::*;

    localparam logic [5:0] NODE_ID = 6'd1;
    localparam logic [5:0] MAX_AGE = 6'd63;
    localparam int         DEPTH   = 4;

    logic    clk = 1'b0;
    logic    rst;
    packet_t ring_i, ring_o, rx_pkt, tx_pkt;
    logic    rx_valid, rx_ready, tx_valid, tx_ready, drop;
    logic [4:0] rxq_count;

    int checks = 0;
    int failures = 0;

    packet_t mq[$];
    packet_t m_ring;
    bit      m_drop;
    bit      m_acc;

    always #5 clk = ~clk;

    nic_ring_node #(.NODE_ID(NODE_ID), .MAX_AGE(MAX_AGE), .RXQ_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .ring_i(ring_i), .ring_o(ring_o),
        .rx_pkt_o(rx_pkt), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .tx_pkt_i(tx_pkt), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .drop_o(drop), .rxq_count_o(rxq_count)
    );

    function automatic packet_t mk(logic [5:0] did, logic [5:0] sid, logic [5:0] age,
                                   logic [3:0] typ, logic [31:0] adr, logic [31:0] dat);
        packet_t p;
        p = '0;
        p.did = did; p.sid = sid; p.age = age; p.typ = typ; p.adr = adr; p.dat = dat;
        p.sel = 4'hF; p.we = (typ == PT_WRITE);
        return p;
    endfunction

    function automatic packet_t rnd_pkt();
        packet_t p;
        p = {$urandom, $urandom, $urandom};
        if ($urandom_range(0, 9) < 3) p.typ = PT_NULL;
        else p.typ = 4'($urandom_range(1, 6));
        if ($urandom_range(0, 9) < 4) p.did = NODE_ID;
        if ($urandom_range(0, 9) < 2) p.age = MAX_AGE;
        return p;
    endfunction

    // A slot is free if empty, consumable into the queue, or too old to forward.
    function automatic bit model_free();
        if (ring_i.typ == PT_NULL) return 1'b1;
        if (ring_i.did == NODE_ID && mq.size() < DEPTH) return 1'b1;
        if (ring_i.age == MAX_AGE) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        packet_t nxt;
        bit      free;
        int      sz;
        sz   = mq.size();
        free = model_free();
        nxt  = '0;
        m_drop = 1'b0;
        if (!free) begin
            nxt = ring_i;
            nxt.age = (ring_i.age >= MAX_AGE) ? MAX_AGE : ring_i.age + 6'd1;
        end else if (ring_i.typ != PT_NULL && !(ring_i.did == NODE_ID && sz < DEPTH)) begin
            m_drop = 1'b1;
        end
        m_acc = free && tx_valid;
        if (m_acc) begin
            nxt = tx_pkt;
            nxt.sid = NODE_ID; nxt.age = '0; nxt.rsvd = '0;
        end
        if (sz > 0 && rx_ready) void'(mq.pop_front());
        if (ring_i.typ != PT_NULL && ring_i.did == NODE_ID && sz < DEPTH) mq.push_back(ring_i);
        m_ring = nxt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ring_i = '0; tx_valid = 1'b0; tx_pkt = '0; rx_ready = 1'b0;
    endtask

    task automatic clear_model();
        mq.delete(); m_ring = '0; m_drop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++; if (ring_o !== 96'h0) begin failures++; $display("FAIL reset_ring_o got=%h exp=0", ring_o); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rxq_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", rxq_count); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop); end
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_local_rx();
        packet_t p;
        p = mk(6'd1, 6'd7, 6'd2, PT_WRITE, 32'h1000, 32'hCAFE);
        idle_inputs();
        ring_i = p;
        step();
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL local_rx_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_pkt !== p) begin failures++; $display("FAIL local_rx_pkt got=%h exp=%h", rx_pkt, p); end
        checks++; if (ring_o.typ !== PT_NULL) begin failures++; $display("FAIL local_ring_null got=%h exp=%h", ring_o.typ, PT_NULL); end
        checks++; if (rxq_count !== 5'd1) begin failures++; $display("FAIL local_count got=%0d exp=1", rxq_count); end
        ring_i = '0; rx_ready = 1'b1;
        step();
        checks++; if (rxq_count !== 5'd0) begin failures++; $display("FAIL local_pop_count got=%0d exp=0", rxq_count); end
        idle_inputs();
    endtask

    task automatic test_transit();
        packet_t p, e;
        p = mk(6'd5, 6'd9, 6'd3, PT_READ, 32'h2000, 32'h0);
        e = p; e.age = 6'd4;
        idle_inputs();
        ring_i = p;
        #1;
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL transit_tx_ready got=%b exp=0", tx_ready); end
        step();
        checks++; if (ring_o !== e) begin failures++; $display("FAIL transit_ring_o got=%h exp=%h", ring_o, e); end
        checks++; if (rxq_count !== 5'd0) begin failures++; $display("FAIL transit_count got=%0d exp=0", rxq_count); end
        idle_inputs();
    endtask

    task automatic test_aged();
        packet_t p, t, e;
        p = mk(6'd5, 6'd9, 6'd63, PT_READ, 32'h3000, 32'h1);
        idle_inputs();
        ring_i = p;
        step();
        checks++; if (ring_o !== 96'h0) begin failures++; $display("FAIL aged_ring_o got=%h exp=0", ring_o); end
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL aged_drop got=%b exp=1", drop); end
        ring_i = '0;
        step();
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL aged_drop_pulse got=%b exp=0", drop); end
        t = mk(6'd4, 6'd22, 6'd11, PT_WRITE, 32'h4444, 32'h5555);
        e = t; e.sid = NODE_ID; e.age = 6'd0;
        ring_i = p; tx_pkt = t; tx_valid = 1'b1;
        #1;
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL aged_tx_ready got=%b exp=1", tx_ready); end
        step();
        checks++; if (ring_o !== e) begin failures++; $display("FAIL aged_inject got=%h exp=%h", ring_o, e); end
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL aged_inject_drop got=%b exp=1", drop); end
        idle_inputs();
        step();
    endtask

    task automatic test_inject();
        packet_t t;
        t = mk(6'd2, 6'h3F, 6'd9, PT_READ, 32'hABCD, 32'h0);
        idle_inputs();
        tx_pkt = t; tx_valid = 1'b1;
        #1;
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL inject_tx_ready got=%b exp=1", tx_ready); end
        step();
        checks++; if (ring_o.sid !== 6'd1) begin failures++; $display("FAIL inject_sid got=%h exp=1", ring_o.sid); end
        checks++; if (ring_o.age !== 6'd0) begin failures++; $display("FAIL inject_age got=%0d exp=0", ring_o.age); end
        checks++; if (ring_o.did !== 6'd2) begin failures++; $display("FAIL inject_did got=%0d exp=2", ring_o.did); end
        checks++; if (ring_o.adr !== 32'hABCD) begin failures++; $display("FAIL inject_adr got=%h exp=abcd", ring_o.adr); end
        idle_inputs();
    endtask

    task automatic test_rxq_full();
        packet_t p[5];
        packet_t p5r, order[4];
        idle_inputs();
        for (int i = 0; i < 5; i++) p[i] = mk(6'd1, 6'd8, 6'd0, PT_WRITE, 32'h100 + i, 32'hD0 + i);
        for (int i = 0; i < 5; i++) begin
            ring_i = p[i];
            step();
        end
        checks++; if (rxq_count !== 5'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", rxq_count); end
        p5r = p[4]; p5r.age = 6'd1;
        checks++; if (ring_o !== p5r) begin failures++; $display("FAIL full_forward got=%h exp=%h", ring_o, p5r); end
        // Pop and recirculated arrival in the same cycle: still full, so it laps again.
        ring_i = p5r; rx_ready = 1'b1;
        step();
        p5r.age = 6'd2;
        checks++; if (rxq_count !== 5'd3) begin failures++; $display("FAIL full_samecycle_count got=%0d exp=3", rxq_count); end
        checks++; if (ring_o !== p5r) begin failures++; $display("FAIL full_samecycle_fwd got=%h exp=%h", ring_o, p5r); end
        ring_i = p5r; rx_ready = 1'b0;
        step();
        checks++; if (rxq_count !== 5'd4) begin failures++; $display("FAIL full_recirc_count got=%0d exp=4", rxq_count); end
        checks++; if (ring_o !== 96'h0) begin failures++; $display("FAIL full_recirc_slot got=%h exp=0", ring_o); end
        order[0] = p[1]; order[1] = p[2]; order[2] = p[3]; order[3] = p5r;
        ring_i = '0; rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_pkt !== order[i]) begin failures++; $display("FAIL full_order[%0d] got=%h exp=%h", i, rx_pkt, order[i]); end
            step();
        end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", rx_valid); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        ring_i = mk(6'd1, 6'd3, 6'd0, PT_READ, 32'h1, 32'h2);
        step();
        ring_i = mk(6'd1, 6'd3, 6'd0, PT_READ, 32'h3, 32'h4);
        step();
        ring_i = mk(6'd9, 6'd3, 6'd5, PT_READ, 32'h5, 32'h6);
        step();
        checks++; if (rxq_count !== 5'd2) begin failures++; $display("FAIL arst_pre_count got=%0d exp=2", rxq_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rxq_count !== 5'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", rxq_count); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL arst_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (ring_o !== 96'h0) begin failures++; $display("FAIL arst_ring_o got=%h exp=0", ring_o); end
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        idle_inputs();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            ring_i   = rnd_pkt();
            rx_ready = ($urandom_range(0, 9) < 4);
            if (!tx_valid && $urandom_range(0, 9) < 5) begin
                tx_pkt   = {$urandom, $urandom, $urandom};
                tx_valid = 1'b1;
            end
            #1;
            checks++; if (tx_ready !== model_free()) begin failures++; $display("FAIL rnd_tx_ready c=%0d got=%b exp=%b", c, tx_ready, model_free()); end
            step();
            if (m_acc) tx_valid = 1'b0;
            checks++; if (ring_o !== m_ring) begin failures++; $display("FAIL rnd_ring_o c=%0d got=%h exp=%h", c, ring_o, m_ring); end
            checks++; if (drop !== m_drop) begin failures++; $display("FAIL rnd_drop c=%0d got=%b exp=%b", c, drop, m_drop); end
            checks++; if (rxq_count !== 5'(mq.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, rxq_count, mq.size()); end
            if (mq.size() > 0) begin
                checks++; if (rx_pkt !== mq[0]) begin failures++; $display("FAIL rnd_rx_pkt c=%0d got=%h exp=%h", c, rx_pkt, mq[0]); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_local_rx();
        test_transit();
        test_aged();
        test_inject();
        test_rxq_full();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
